// File: rtl/pipelined_multiplier_arbiter_pkg.sv
// Shared types for the pipelined multiplier arbiter: tag-pipeline entries, output-register
// entries and the tag-width helper.
package pipelined_multiplier_arbiter_pkg;

    // Struct fields are sized for the widest supported configuration; users slice what they need.
    localparam int unsigned TAG_MAX_W     = 8;
    localparam int unsigned PRODUCT_MAX_W = 128;

    function automatic int unsigned tag_w(input int unsigned requesters);
        return (requesters > 1) ? $clog2(requesters) : 1;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
    } tag_entry_t;

    typedef struct packed {
        logic                     valid;
        logic [TAG_MAX_W-1:0]     tag;
        logic [PRODUCT_MAX_W-1:0] product;
    } out_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr, wrapping.
module rr_arbiter
    import pipelined_multiplier_arbiter_pkg::*;
#(
    parameter int unsigned REQUESTERS = 4,
    localparam int unsigned TAG_W = tag_w(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] req,
    input  logic [TAG_W-1:0]      ptr,
    input  logic                  enable,
    output logic [REQUESTERS-1:0] grant,
    output logic [TAG_W-1:0]      grant_idx,
    output logic                  any_grant
);

    logic [TAG_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < REQUESTERS; k++) begin
            idx = TAG_W'((32'(ptr) + k) % REQUESTERS);
            if (enable && !any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipelined_multiplier_arbiter.sv
// Round-robin front end sharing one pipelined multiplier between several clients; requester
// tags travel alongside the operands and products return through a one-entry output register.
module pipelined_multiplier_arbiter
    import pipelined_multiplier_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned PIPELINE_DEPTH = 8,
    parameter int unsigned REQUESTERS     = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [REQUESTERS-1:0]                  req_valid_i,
    output logic [REQUESTERS-1:0]                  req_ready_o,
    input  logic [REQUESTERS-1:0][DATA_WIDTH-1:0]  req_multiplicand_i,
    input  logic [REQUESTERS-1:0][DATA_WIDTH-1:0]  req_multiplier_i,
    output logic [REQUESTERS-1:0]                  rsp_valid_o,
    input  logic [REQUESTERS-1:0]                  rsp_ready_i,
    output logic [2*DATA_WIDTH-1:0]                rsp_product_o,
    output logic [DATA_WIDTH-1:0]                  mul_multiplicand_o,
    output logic [DATA_WIDTH-1:0]                  mul_multiplier_o,
    output logic                                   mul_valid_o,
    output logic                                   mul_clk_en_o,
    input  logic [2*DATA_WIDTH-1:0]                mul_product_i,
    input  logic                                   mul_valid_i
);

    localparam int unsigned TAG_W = tag_w(REQUESTERS);
    localparam int unsigned LAT   = PIPELINE_DEPTH - 1;

    tag_entry_t       tag_pipe_q [LAT];
    tag_entry_t       head;
    out_entry_t       out_q, out_d;
    logic [TAG_W-1:0] ptr_q, ptr_d;
    logic [TAG_W-1:0] out_tag, grant_idx;
    logic [REQUESTERS-1:0] grant;
    logic             any_grant;
    logic             accept, stall;
    logic             unused_bits;

    assign head    = tag_pipe_q[LAT-1];
    assign out_tag = out_q.tag[TAG_W-1:0];

    // Only freeze the multiplier when its finished result has nowhere to go.
    assign accept       = out_q.valid & rsp_ready_i[out_tag];
    assign stall        = ~rst_i & mul_valid_i & out_q.valid & ~accept;
    assign mul_clk_en_o = ~stall;

    rr_arbiter #(
        .REQUESTERS (REQUESTERS)
    ) u_rr_arbiter (
        .req       (req_valid_i),
        .ptr       (ptr_q),
        .enable    (~stall & ~rst_i),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign req_ready_o        = grant;
    assign mul_valid_o        = any_grant;
    assign mul_multiplicand_o = any_grant ? req_multiplicand_i[grant_idx] : '0;
    assign mul_multiplier_o   = any_grant ? req_multiplier_i[grant_idx] : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (any_grant) begin
            ptr_d = (grant_idx == TAG_W'(REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // A new product may enter in the same cycle the previous one is accepted.
    always_comb begin
        out_d = out_q;
        if (mul_valid_i && !stall) begin
            out_d.valid   = 1'b1;
            out_d.tag     = head.tag;
            out_d.product = PRODUCT_MAX_W'(mul_product_i);
        end else if (accept) begin
            out_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            out_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_pipe_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            out_q <= out_d;
            if (mul_clk_en_o) begin
                tag_pipe_q[0].valid <= mul_valid_o;
                tag_pipe_q[0].tag   <= TAG_MAX_W'(grant_idx);
                for (int i = 1; i < LAT; i++) begin
                    tag_pipe_q[i] <= tag_pipe_q[i-1];
                end
            end
        end
    end

    assign rsp_valid_o   = out_q.valid ? (REQUESTERS'(1) << out_tag) : '0;
    assign rsp_product_o = out_q.product[2*DATA_WIDTH-1:0];

    assign unused_bits = ^{out_q.tag, out_q.product, head};

endmodule

// File: tb/tb_pipelined_multiplier_arbiter.sv
// Self-checking bench: behavioural multiplier, issue-order scoreboard and directed scenarios.
module tb_pipelined_multiplier_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned R     = 4;
    localparam int unsigned L     = DEPTH - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [R-1:0]         req_valid, req_ready, rsp_valid, rsp_ready;
    logic [R-1:0][DW-1:0] req_a, req_b;
    logic [2*DW-1:0]      rsp_product, mul_product;
    logic [DW-1:0]        mul_a, mul_b;
    logic                 mul_vo, mul_clk_en, mul_vi;

    pipelined_multiplier_arbiter #(
        .DATA_WIDTH     (DW),
        .PIPELINE_DEPTH (DEPTH),
        .REQUESTERS     (R)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_multiplicand_i (req_a),
        .req_multiplier_i   (req_b),
        .rsp_valid_o        (rsp_valid),
        .rsp_ready_i        (rsp_ready),
        .rsp_product_o      (rsp_product),
        .mul_multiplicand_o (mul_a),
        .mul_multiplier_o   (mul_b),
        .mul_valid_o        (mul_vo),
        .mul_clk_en_o       (mul_clk_en),
        .mul_product_i      (mul_product),
        .mul_valid_i        (mul_vi)
    );

    // Behavioural stand-in for the shared multiplier: L enabled cycles of latency.
    logic [2*DW-1:0] mp_prod [L];
    logic            mp_v    [L];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L; i++) mp_v[i] <= 1'b0;
        end else if (mul_clk_en) begin
            mp_v[0]    <= mul_vo;
            mp_prod[0] <= 64'(mul_a) * 64'(mul_b);
            for (int i = 1; i < L; i++) begin
                mp_v[i]    <= mp_v[i-1];
                mp_prod[i] <= mp_prod[i-1];
            end
        end
    end
    assign mul_vi      = mp_v[L-1];
    assign mul_product = mp_prod[L-1];

    typedef struct {
        int          tag;
        logic [63:0] prod;
    } exp_t;

    exp_t exp_q     [$];
    int   grant_log [$];
    int   rsp_log   [$];
    int   exp_gr    [$];
    int   checks    = 0;
    int   errors    = 0;
    int   cycle     = 0;
    int   stall_cnt = 0;
    int   exp_ptr   = 0;
    int   n;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Per-cycle checks, sampled mid-cycle while combinational outputs are stable.
    task automatic monitor();
        logic [R-1:0] xfer;
        int g, eg;
        chk("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
        if (rst) chk("ready_in_reset", 64'(req_ready), 64'd0);
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                chk("rsp_client", 64'(rsp_valid), 64'(4'b0001 << exp_q[0].tag));
                chk("rsp_product", rsp_product, exp_q[0].prod);
                if ((rsp_valid & rsp_ready) != '0) begin
                    void'(exp_q.pop_front());
                    rsp_log.push_back(cycle);
                end
            end
        end
        if (!rst) begin
            chk("clk_en", 64'(mul_clk_en),
                64'(!(mul_vi && rsp_valid != '0 && (rsp_valid & rsp_ready) == '0)));
        end
        if (!mul_clk_en) begin
            stall_cnt++;
            chk("stall_quiet", 64'({req_ready, mul_vo}), 64'd0);
        end else begin
            chk("tag_head_valid", 64'(mul_vi), 64'(dut.tag_pipe_q[L-1].valid));
            if (!rst && req_valid != '0) chk("grant_when_free", 64'(req_ready != '0), 64'd1);
        end
        xfer = req_valid & req_ready;
        if (xfer == '0) begin
            chk("mul_valid_idle", 64'(mul_vo), 64'd0);
        end else begin
            g = 0;
            for (int i = 0; i < R; i++) if (xfer[i]) g = i;
            eg = -1;
            for (int k = 0; k < R; k++) begin
                if (eg < 0 && req_valid[(exp_ptr + k) % R]) eg = (exp_ptr + k) % R;
            end
            chk("rr_grant", 64'(g), 64'(eg));
            exp_ptr = (g + 1) % R;
            chk("mul_valid_grant", 64'(mul_vo), 64'd1);
            chk("mul_a", 64'(mul_a), 64'(req_a[g]));
            chk("mul_b", 64'(mul_b), 64'(req_b[g]));
            exp_q.push_back('{tag: g, prod: 64'(req_a[g]) * 64'(req_b[g])});
            grant_log.push_back(g);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cycle++;
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < R; i++) begin
            req_a[i] = $urandom;
            req_b[i] = $urandom;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_ptr = 0;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_grants(input string name);
        chk(name, 64'(grant_log.size()), 64'(exp_gr.size()));
        for (int i = 0; i < exp_gr.size(); i++) chk(name, 64'(grant_log[i]), 64'(exp_gr[i]));
    endtask

    task automatic poll_rsp();
        n = 1;
        while (rsp_valid == '0 && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        req_valid = '0;
        rsp_ready = '1;
        req_a     = '0;
        req_b     = '0;
        do_reset();
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_mul_valid", 64'(mul_vo), 64'd0);
        chk("reset_clk_en", 64'(mul_clk_en), 64'd1);

        // Single operation from client 0: 3*5 appears 8 cycles after the grant.
        req_a[0] = 32'd3;
        req_b[0] = 32'd5;
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        poll_rsp();
        chk("t1_latency", 64'(n), 64'd8);
        chk("t1_rsp_valid", 64'(rsp_valid), 64'b0001);
        chk("t1_product", rsp_product, 64'd15);
        drain();

        // Client 2 full-scale operands; leaves the pointer at 3.
        req_a[2] = 32'hFFFF_FFFF;
        req_b[2] = 32'hFFFF_FFFF;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        poll_rsp();
        chk("t3_rsp_valid", 64'(rsp_valid), 64'b0100);
        chk("t3_product", rsp_product, 64'hFFFF_FFFE_0000_0001);
        drain();

        // Only clients 3 and 0: pointer wraps, grants alternate.
        grant_log.delete();
        req_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            tick();
        end
        req_valid = '0;
        exp_gr = '{3, 0, 3, 0};
        check_grants("t6_grants");
        drain();

        // All clients streaming with every response accepted: one per cycle, no stall.
        do_reset();
        grant_log.delete();
        rsp_log.delete();
        stall_cnt = 0;
        req_valid = '1;
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            tick();
        end
        req_valid = '0;
        exp_gr = '{0, 1, 2, 3, 0, 1};
        check_grants("t2_grants");
        drain();
        chk("t2_no_stall", 64'(stall_cnt), 64'd0);
        chk("t2_rsp_count", 64'(rsp_log.size()), 64'd6);
        chk("t2_back_to_back", 64'(rsp_log[rsp_log.size()-1] - rsp_log[0]), 64'd5);

        // Streaming with client 0 refusing responses for 5 cycles.
        grant_log.delete();
        rsp_log.delete();
        stall_cnt = 0;
        req_valid = '1;
        for (int i = 0; i < 20; i++) begin
            rand_ops();
            rsp_ready = (i >= 10 && i < 15) ? 4'b1110 : 4'b1111;
            tick();
        end
        drain();
        chk("t4_stalled", 64'(stall_cnt > 0), 64'd1);
        chk("t4_stall_bound", 64'(stall_cnt <= 5), 64'd1);
        chk("t4_no_loss", 64'(rsp_log.size()), 64'(grant_log.size()));

        // Reset with four operations in flight.
        req_valid = '1;
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            tick();
        end
        rst = 1'b1;
        #1;
        chk("t5_ready_in_rst", 64'(req_ready), 64'd0);
        chk("t5_mul_valid_in_rst", 64'(mul_vo), 64'd0);
        tick();
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_mul_valid", 64'(mul_vo), 64'd0);
        chk("t5_clk_en", 64'(mul_clk_en), 64'd1);
        rst = 1'b0;
        exp_q.delete();
        exp_ptr = 0;
        #1;
        chk("t5_ptr_zero", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        drain();
        for (int i = 0; i < 15; i++) tick();
        chk("t5_no_stale", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
